// File: rtl/qspi_sram_responder_if.sv
// Bus bundle between a quad-SPI SRAM initiator, the responder and its backing memory.
interface qspi_sram_responder_if #(
    parameter int MEM_ADDR_WIDTH = 16
);
    logic                      sram_cs_n;
    logic                      sram_sck;
    logic [3:0]                sram_sio_i;
    logic [3:0]                sram_sio_o;
    logic                      sram_sio_oe;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic                      mem_re;
    logic [7:0]                mem_rdata;
    logic                      mem_we;
    logic [7:0]                mem_wdata;
    logic                      quad_mode;
    logic                      cmd_error;

    // Responder side
    modport slave (
        input  sram_cs_n, sram_sck, sram_sio_i, mem_rdata,
        output sram_sio_o, sram_sio_oe, mem_addr, mem_re, mem_we, mem_wdata,
        quad_mode, cmd_error
    );

    // Initiator / memory side
    modport master (
        output sram_cs_n, sram_sck, sram_sio_i, mem_rdata,
        input  sram_sio_o, sram_sio_oe, mem_addr, mem_re, mem_we, mem_wdata,
        quad_mode, cmd_error
    );
endinterface

// File: rtl/qspi_sram_responder.sv
// Device-side quad-SPI serial SRAM: oversamples the SIO bus in the clk domain,
// decodes EQIO/RSTQIO/READ/WRITE and serves data from a byte-wide memory port.
module qspi_sram_responder #(
    parameter int ADDR_WIDTH     = 24,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int DUMMY_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    qspi_sram_responder_if.slave  bus
);
    localparam logic [7:0]            ADDR_LAST  = 8'(ADDR_WIDTH / 4 - 1);
    localparam logic [7:0]            DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
    } state_t;

    state_t r_state, w_state_n;

    logic [1:0] r_cs_sync, r_sck_sync;
    logic [3:0] r_sio_m, r_sio;
    logic       r_cs_d, r_sck_d;

    logic [7:0]                r_shift;
    logic [7:0]                r_cnt;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [7:0]                r_rbuf, r_nbuf;
    logic                      r_nib, r_is_read, r_re_d, r_quad;
    logic [3:0]                r_sio_o;
    logic                      r_oe, r_mem_re, r_mem_we, r_cmd_error;
    logic [MEM_ADDR_WIDTH-1:0] r_mem_addr;
    logic [7:0]                r_mem_wdata;

    logic                  w_cs_hi, w_cs_fall, w_rise, w_fall;
    logic [7:0]            w_op;
    logic                  w_cmd_last, w_addr_last, w_dummy_last;
    logic                  w_eqio, w_read, w_write, w_rstqio;
    logic [ADDR_WIDTH-1:0] w_addr_n;

    assign w_cs_hi      = r_cs_sync[1];
    assign w_cs_fall    = ~r_cs_sync[1] & r_cs_d;
    assign w_rise       = r_sck_sync[1] & ~r_sck_d;
    assign w_fall       = ~r_sck_sync[1] & r_sck_d;
    assign w_op         = r_quad ? {r_shift[3:0], r_sio} : {r_shift[6:0], r_sio[0]};
    assign w_cmd_last   = r_quad ? (r_cnt == 8'd1) : (r_cnt == 8'd7);
    assign w_addr_last  = (r_cnt == ADDR_LAST);
    assign w_dummy_last = (r_cnt == DUMMY_LAST);
    assign w_addr_n     = {r_addr[ADDR_WIDTH-5:0], r_sio};
    assign w_eqio       = ~r_quad & (w_op == 8'h38);
    assign w_read       =  r_quad & (w_op == 8'h03);
    assign w_write      =  r_quad & (w_op == 8'h02);
    assign w_rstqio     =  r_quad & (w_op == 8'hFF);

    assign bus.sram_sio_o  = r_sio_o;
    assign bus.sram_sio_oe = r_oe;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_re      = r_mem_re;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.quad_mode   = r_quad;
    assign bus.cmd_error   = r_cmd_error;

    // Two-flop synchronizers plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_sync  <= 2'b11;
            r_sck_sync <= 2'b00;
            r_sio_m    <= 4'h0;
            r_sio      <= 4'h0;
            r_cs_d     <= 1'b1;
            r_sck_d    <= 1'b0;
        end else begin
            r_cs_sync  <= {r_cs_sync[0], bus.sram_cs_n};
            r_sck_sync <= {r_sck_sync[0], bus.sram_sck};
            r_sio_m    <= bus.sram_sio_i;
            r_sio      <= r_sio_m;
            r_cs_d     <= r_cs_sync[1];
            r_sck_d    <= r_sck_sync[1];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_n;
    end

    // Next-state decode; deselect wins over everything
    always_comb begin
        w_state_n = r_state;
        if (w_cs_hi) begin
            w_state_n = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_cs_fall) w_state_n = S_CMD;
                S_CMD:    if (w_rise && w_cmd_last)
                              w_state_n = (w_read || w_write) ? S_ADDR : S_IGNORE;
                S_ADDR:   if (w_rise && w_addr_last)
                              w_state_n = r_is_read ? S_DUMMY : S_WDATA;
                S_DUMMY:  if (w_rise && w_dummy_last) w_state_n = S_RDATA;
                default:  w_state_n = r_state;
            endcase
        end
    end

    // Datapath: shifting, address tracking, memory strobes and SIO drive
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift     <= 8'h00;
            r_cnt       <= 8'h00;
            r_addr      <= '0;
            r_rbuf      <= 8'h00;
            r_nbuf      <= 8'h00;
            r_nib       <= 1'b0;
            r_is_read   <= 1'b0;
            r_re_d      <= 1'b0;
            r_quad      <= 1'b0;
            r_sio_o     <= 4'h0;
            r_oe        <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_cmd_error <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h00;
        end else begin
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_cmd_error <= 1'b0;
            r_re_d      <= r_mem_re;
            if (w_cs_hi) begin
                r_oe  <= 1'b0;
                r_cnt <= 8'h00;
                r_nib <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt   <= 8'h00;
                        r_shift <= 8'h00;
                        r_nib   <= 1'b0;
                    end
                    S_CMD: if (w_rise) begin
                        r_shift <= w_op;
                        r_cnt   <= r_cnt + 8'd1;
                        if (w_cmd_last) begin
                            r_cnt     <= 8'h00;
                            r_is_read <= w_read;
                            if (w_eqio)   r_quad <= 1'b1;
                            if (w_rstqio) r_quad <= 1'b0;
                            if (!(w_eqio || w_read || w_write || w_rstqio)) r_cmd_error <= 1'b1;
                        end
                    end
                    S_ADDR: if (w_rise) begin
                        r_addr <= w_addr_n;
                        r_cnt  <= r_cnt + 8'd1;
                        if (w_addr_last) begin
                            r_cnt <= 8'h00;
                            if (r_is_read) begin
                                r_mem_addr <= w_addr_n[MEM_ADDR_WIDTH-1:0];
                                r_mem_re   <= 1'b1;
                            end
                        end
                    end
                    S_DUMMY: begin
                        if (r_re_d) r_rbuf <= bus.mem_rdata;
                        if (w_rise) begin
                            r_cnt <= r_cnt + 8'd1;
                            if (w_dummy_last) begin
                                r_addr <= r_addr + ADDR_ONE;
                                r_oe   <= 1'b1;
                                r_nib  <= 1'b0;
                            end
                        end
                    end
                    S_RDATA: begin
                        // prefetched byte lands here while the low nibble is still pending
                        if (r_re_d) r_nbuf <= bus.mem_rdata;
                        if (w_fall) begin
                            if (!r_nib) begin
                                r_sio_o    <= r_rbuf[7:4];
                                r_mem_addr <= r_addr[MEM_ADDR_WIDTH-1:0];
                                r_mem_re   <= 1'b1;
                                r_nib      <= 1'b1;
                            end else begin
                                r_sio_o <= r_rbuf[3:0];
                                r_rbuf  <= r_nbuf;
                                r_addr  <= r_addr + ADDR_ONE;
                                r_nib   <= 1'b0;
                            end
                        end
                    end
                    S_WDATA: if (w_rise) begin
                        if (!r_nib) begin
                            r_shift[3:0] <= r_sio;
                            r_nib        <= 1'b1;
                        end else begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_addr[MEM_ADDR_WIDTH-1:0];
                            r_mem_wdata <= {r_shift[3:0], r_sio};
                            r_addr      <= r_addr + ADDR_ONE;
                            r_nib       <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qspi_sram_responder.sv
// Directed + randomized bench: drives the SIO bus like an initiator, backs the
// responder with a byte array and checks against a plain byte-array model.
module tb_qspi_sram_responder;
    localparam int H = 6;  // SCK half period in clk cycles

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    qspi_sram_responder_if #(.MEM_ADDR_WIDTH(16)) bus ();

    qspi_sram_responder #(
        .ADDR_WIDTH(24), .MEM_ADDR_WIDTH(16), .DUMMY_CYCLES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    // Backing memory seen by the DUT (one-clk read latency)
    logic [7:0] sram  [0:65535];
    // Expected contents, maintained only from what the bench asked to write
    logic [7:0] model [0:65535];

    always @(posedge clk) begin
        if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= sram[bus.mem_addr];
    end

    // Strobe logging
    logic [23:0] we_log[$];
    logic [15:0] re_log[$];
    int errcnt = 0, both_cnt = 0, oe_cnt = 0;

    always @(negedge clk) begin
        if (bus.mem_we) we_log.push_back({bus.mem_addr, bus.mem_wdata});
        if (bus.mem_re) re_log.push_back(bus.mem_addr);
        if (bus.cmd_error) errcnt++;
        if (bus.mem_re && bus.mem_we) both_cnt++;
        if (bus.sram_sio_oe) oe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_lo();
        bus.sram_cs_n = 1'b0;
        tick(4);
    endtask

    task automatic cs_hi();
        bus.sram_sck  = 1'b0;
        bus.sram_cs_n = 1'b1;
        tick(6);
    endtask

    // One SCK period: present o, sample the bus just before the rising edge
    task automatic nib(input logic [3:0] o, output logic [3:0] r, output logic oe);
        bus.sram_sio_i = o;
        tick(H);
        r  = bus.sram_sio_o;
        oe = bus.sram_sio_oe;
        bus.sram_sck = 1'b1;
        tick(H);
        bus.sram_sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        logic [3:0] r; logic oe;
        for (int i = 7; i >= 0; i--) nib({3'b000, b[i]}, r, oe);
    endtask

    task automatic quad_hdr(input logic [7:0] op, input logic [23:0] a);
        logic [3:0] r; logic oe;
        nib(op[7:4], r, oe);
        nib(op[3:0], r, oe);
        for (int i = 5; i >= 0; i--) nib(a[i*4 +: 4], r, oe);
    endtask

    task automatic quad_write(input logic [23:0] a, input logic [7:0] d[$]);
        logic [3:0] r; logic oe; logic [23:0] ai;
        cs_lo();
        quad_hdr(8'h02, a);
        for (int i = 0; i < d.size(); i++) begin
            nib(d[i][7:4], r, oe);
            nib(d[i][3:0], r, oe);
            ai = a + 24'(i);
            model[ai[15:0]] = d[i];
        end
        cs_hi();
    endtask

    task automatic quad_read(input logic [23:0] a, input int n, output logic [7:0] got[$],
                             output int oe_bad, output logic oe_after);
        logic [3:0] hi, lo; logic oe;
        got = {};
        oe_bad = 0;
        cs_lo();
        quad_hdr(8'h03, a);
        for (int i = 0; i < 2; i++) begin
            nib($urandom_range(0, 15), hi, oe);
            if (oe) oe_bad++;
        end
        for (int i = 0; i < n; i++) begin
            nib($urandom_range(0, 15), hi, oe);
            if (!oe) oe_bad++;
            nib($urandom_range(0, 15), lo, oe);
            if (!oe) oe_bad++;
            got.push_back({hi, lo});
        end
        bus.sram_cs_n = 1'b1;
        tick(3);
        oe_after = bus.sram_sio_oe;
        tick(3);
    endtask

    initial begin
        logic [7:0]  wd[$];
        logic [7:0]  got[$];
        logic [23:0] a, ai;
        logic [3:0]  r;
        logic        oe, oe_after;
        int          oe_bad, e0, w0, r0, o0, n;

        bus.sram_cs_n  = 1'b1;
        bus.sram_sck   = 1'b0;
        bus.sram_sio_i = 4'h0;
        tick(3);
        chk("rst_quad",  32'(bus.quad_mode), 0);
        chk("rst_oe",    32'(bus.sram_sio_oe), 0);
        chk("rst_sio",   32'(bus.sram_sio_o), 0);
        chk("rst_re_we", 32'({bus.mem_re, bus.mem_we}), 0);
        chk("rst_addr",  32'(bus.mem_addr), 0);
        chk("rst_wdata", 32'(bus.mem_wdata), 0);
        chk("rst_cmderr", 32'(bus.cmd_error), 0);
        reset_n = 1'b1;
        tick(4);

        // EQIO in SPI mode
        e0 = errcnt; o0 = oe_cnt;
        cs_lo(); spi_byte(8'h38); cs_hi();
        chk("eqio_quad", 32'(bus.quad_mode), 1);
        chk("eqio_err",  32'(errcnt - e0), 0);
        chk("eqio_oe",   32'(oe_cnt - o0), 0);

        // WRITE A5 3C at 0x000123
        w0 = we_log.size();
        wd = {}; wd.push_back(8'hA5); wd.push_back(8'h3C);
        quad_write(24'h000123, wd);
        chk("wr_count", 32'(we_log.size() - w0), 2);
        if (we_log.size() >= w0 + 2) begin
            chk("wr_0", 32'(we_log[w0]),   32'h0123A5);
            chk("wr_1", 32'(we_log[w0+1]), 32'h01243C);
        end

        // READ it back
        quad_read(24'h000123, 2, got, oe_bad, oe_after);
        chk("rd_b0", 32'(got[0]), 32'hA5);
        chk("rd_b1", 32'(got[1]), 32'h3C);
        chk("rd_oe_window", 32'(oe_bad), 0);
        chk("rd_oe_release", 32'(oe_after), 0);

        // Address wrap on write
        w0 = we_log.size();
        wd = {}; wd.push_back(8'($urandom)); wd.push_back(8'($urandom));
        quad_write(24'hFFFFFF, wd);
        chk("wrapw_count", 32'(we_log.size() - w0), 2);
        if (we_log.size() >= w0 + 2) begin
            chk("wrapw_a0", 32'(we_log[w0][23:8]),   32'hFFFF);
            chk("wrapw_a1", 32'(we_log[w0+1][23:8]), 32'h0000);
        end

        // Address wrap on read
        r0 = re_log.size();
        quad_read(24'hFFFFFF, 2, got, oe_bad, oe_after);
        chk("wrapr_count_ge2", 32'(re_log.size() - r0 >= 2), 1);
        if (re_log.size() >= r0 + 2) begin
            chk("wrapr_a0", 32'(re_log[r0]),   32'hFFFF);
            chk("wrapr_a1", 32'(re_log[r0+1]), 32'h0000);
        end
        chk("wrapr_b0", 32'(got[0]), 32'(model[16'hFFFF]));
        chk("wrapr_b1", 32'(got[1]), 32'(model[16'h0000]));

        // Randomized write/read-back bursts
        for (int t = 0; t < 4; t++) begin
            a = 24'($urandom);
            n = $urandom_range(1, 4);
            wd = {};
            for (int i = 0; i < n; i++) wd.push_back(8'($urandom));
            w0 = we_log.size();
            quad_write(a, wd);
            chk("rnd_wcount", 32'(we_log.size() - w0), 32'(n));
            quad_read(a, n, got, oe_bad, oe_after);
            chk("rnd_oe", 32'(oe_bad), 0);
            for (int i = 0; i < n; i++) begin
                ai = a + 24'(i);
                chk("rnd_data", 32'(got[i]), 32'(model[ai[15:0]]));
            end
        end

        // Aborted write: three nibbles then deselect
        w0 = we_log.size();
        cs_lo();
        quad_hdr(8'h02, 24'h004000);
        nib(4'h1, r, oe); nib(4'h2, r, oe); nib(4'h3, r, oe);
        cs_hi();
        model[16'h4000] = 8'h12;
        chk("abort_we", 32'(we_log.size() - w0), 1);

        // Unknown opcode in quad mode
        e0 = errcnt; w0 = we_log.size(); r0 = re_log.size();
        cs_lo(); nib(4'h9, r, oe); nib(4'hF, r, oe); tick(4); cs_hi();
        chk("bad_err",  32'(errcnt - e0), 1);
        chk("bad_mem",  32'((we_log.size() - w0) + (re_log.size() - r0)), 0);
        chk("bad_quad", 32'(bus.quad_mode), 1);

        // RSTQIO
        e0 = errcnt;
        cs_lo(); nib(4'hF, r, oe); nib(4'hF, r, oe); cs_hi();
        chk("rstqio_quad", 32'(bus.quad_mode), 0);
        chk("rstqio_err",  32'(errcnt - e0), 0);

        // READ opcode in SPI mode is unsupported
        e0 = errcnt;
        cs_lo(); spi_byte(8'h03); cs_hi();
        chk("spi_read_err", 32'(errcnt - e0), 1);

        // Async reset in the middle of a read burst
        cs_lo(); spi_byte(8'h38); cs_hi();
        cs_lo();
        quad_hdr(8'h03, 24'h000123);
        nib(4'h0, r, oe); nib(4'h0, r, oe);
        nib(4'h0, r, oe); nib(4'h0, r, oe);
        chk("mid_oe", 32'(bus.sram_sio_oe), 1);
        reset_n = 1'b0;
        #1;
        chk("arst_oe",   32'(bus.sram_sio_oe), 0);
        chk("arst_quad", 32'(bus.quad_mode), 0);
        bus.sram_cs_n = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(4);

        chk("no_re_we_overlap", 32'(both_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/qspi_sram_responder.md
Name: qspi_sram_responder

Overview:
- Synthesizable device-side model of the quad-SPI serial SRAM that the spi_sram_encoder drives: decodes commands, address and data from the SIO lines and serves them from a byte-wide backing-memory port.
- Used on-chip or in FPGA builds to stand in for external RAM/ROM/VRAM chips, and as an in-bench responder for encoder verification.
- Bus inputs are oversampled in the clk domain.

Parameters:
- ADDR_WIDTH, 24, byte-address bits carried on the bus (multiple of 4).
- MEM_ADDR_WIDTH, 16, backing-memory address bits; bus address is truncated to the LSBs.
- DUMMY_CYCLES, 2, SCK cycles between the last address nibble and the first read-data nibble.

Ports:
- clk  in  1  system clock; must be ≥8× SCK frequency.
- reset_n  in  1  asynchronous active-low reset.
- sram_cs_n  in  1  chip select from initiator, active low.
- sram_sck  in  1  serial clock from initiator.
- sram_sio_i  in  4  SIO[3:0] sampled from bus; SIO0 = SI in SPI mode.
- sram_sio_o  out  4  SIO[3:0] driven to bus.
- sram_sio_oe  out  1  output enable for sram_sio_o.
- mem_addr  out  MEM_ADDR_WIDTH  backing-memory byte address.
- mem_re  out  1  one-clk read strobe.
- mem_rdata  in  8  read data, valid the clk after mem_re.
- mem_we  out  1  one-clk write strobe.
- mem_wdata  out  8  write data, valid with mem_we.
- quad_mode  out  1  1 = quad I/O mode active.
- cmd_error  out  1  one-clk pulse on an unsupported opcode.

Behaviour:
- Synchronization: cs_n, sck and sio_i each pass through 2-flop synchronizers.
  - sck_rise and sck_fall are single-clk pulses from the synchronized sck.
  - Decoding uses synchronized values only.
  - Allowed SCK timing: each high and low phase ≥ 4 clk.
- Reset (reset_n low, async): state IDLE, quad_mode=0, sram_sio_oe=0, sram_sio_o=0, mem_re=mem_we=0, mem_wdata=0, mem_addr=0, cmd_error=0, address/shift/count registers 0.
- cs_n high (synced) in any state: next clk → IDLE, sram_sio_oe=0.
  - A partially received write byte is discarded; no mem_we.
  - quad_mode is kept.
- Bits and nibbles are MSB first; all bus sampling happens on sck_rise.
- IDLE: on cs_n falling → CMD, clear shift counter.
- CMD:
  - SPI mode: 8 bits from SIO0.
  - Quad mode: 2 nibbles from SIO[3:0].
  - Decode on completion, per mode:
    - SPI mode, opcode 0x38 (EQIO): quad_mode←1, → IGNORE.
    - Quad mode, opcode 0x03 (READ): → ADDR.
    - Quad mode, opcode 0x02 (WRITE): → ADDR.
    - Quad mode, opcode 0xFF (RSTQIO): quad_mode←0, → IGNORE.
    - Any other opcode in either mode: cmd_error pulse, → IGNORE.
- ADDR: ADDR_WIDTH/4 nibbles into addr register. On completion:
  - READ: mem_addr←addr[MEM_ADDR_WIDTH-1:0], mem_re pulse, → DUMMY.
  - WRITE: → WDATA.
- DUMMY: count DUMMY_CYCLES sck_rise.
  - Capture mem_rdata into the read byte buffer.
  - Increment addr, modulo 2^ADDR_WIDTH.
  - On the last dummy sck_rise: assert sram_sio_oe, → RDATA.
- RDATA:
  - On each sck_fall, drive the next nibble (high nibble first) on sram_sio_o.
  - After the high nibble is driven, issue mem_re for addr (prefetch) and capture its data into a next-byte register.
  - After the low nibble is driven, load that byte and increment addr.
  - Stream continues until cs_n rises. First nibble is driven on the first sck_fall after entering RDATA.
  - addr wraps 2^ADDR_WIDTH-1 → 0.
- WDATA:
  - Two nibbles per byte; on the 2nd nibble, mem_we pulse with mem_addr=addr and mem_wdata=byte, then addr increments with wrap.
- IGNORE: no bus drive and no memory access until cs_n high.
- sram_sio_oe is high only in RDATA (from the end of DUMMY); SPI mode never drives SIO.
- mem_re and mem_we are never asserted in the same clk.

Test Plan:
- EQIO: SPI byte 0x38 → quad_mode=1; cmd_error=0; sram_sio_oe stays 0.
- Quad WRITE 0x02, addr 0x000123, data 0xA5 0x3C → mem_we twice: (0x0123,0xA5), (0x0124,0x3C); no third strobe.
- Quad READ 0x03, addr 0x000123, 2 dummy cycles, memory holds A5 3C → sio_o nibbles A,5,3,C on successive sck_fall; oe high only during data; cs_n high → oe=0 within 3 clk.
- Wrap: READ at 0xFFFFFF for 2 bytes → mem_addr sequence 0xFFFF then 0x0000. WRITE at 0xFFFFFF for 2 bytes → same address sequence.
- Abort: WRITE with 3 nibbles then cs_n high → exactly one mem_we. Unknown opcode 0x9F in quad mode → cmd_error pulse, no mem access.
- RSTQIO 0xFF → quad_mode=0. Then reset_n low mid-READ → oe=0, quad_mode=0 asynchronously.
